// File: rtl/zc_spi_pkg.sv
// Shared types and default divider constants for the zc SPI master.
package zc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } zc_spi_state_t;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_SLOW_DIV = 64;

endpackage

// File: rtl/zc_spi_master.sv
// Byte-wide SPI mode-0 master with selectable fast/slow SCK divider and a
// registered chip select that can be written at any time.
module zc_spi_master
    import zc_spi_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SLOW_DIV = DEF_SLOW_DIV
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cs_wr,
    input  logic       dat_wr,
    input  logic       dat_rd,
    input  logic [7:0] din,
    input  logic       slow,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       SD_CLK,
    output logic       SD_SI,
    input  logic       SD_SO,
    output logic       SD_CS_N
);

    localparam logic [7:0] FAST_DIV_L = 8'(CLK_DIV);
    localparam logic [7:0] SLOW_DIV_L = 8'(SLOW_DIV);

    zc_spi_state_t state_q;
    logic [7:0]    div_q;
    logic [7:0]    div_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [7:0]    dout_q;
    logic          busy_q;
    logic          done_q;
    logic          sck_q;
    logic          cs_n_q;

    wire half_end = (div_cnt_q == div_q - 8'd1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= FAST_DIV_L;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'hFF;
            rx_q      <= 8'h00;
            dout_q    <= 8'hFF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            // Chip select is independent of the transfer engine.
            if (cs_wr) begin
                cs_n_q <= din[0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (dat_wr || dat_rd) begin
                        tx_q      <= dat_wr ? din : 8'hFF;
                        div_q     <= slow ? SLOW_DIV_L : FAST_DIV_L;
                        div_cnt_q <= 8'd0;
                        bit_cnt_q <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (half_end) begin
                        div_cnt_q <= 8'd0;
                        sck_q     <= 1'b1;
                        rx_q      <= {rx_q[6:0], SD_SO};
                        state_q   <= ST_HI;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                ST_HI: begin
                    if (half_end) begin
                        div_cnt_q <= 8'd0;
                        sck_q     <= 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            // Park MOSI high so the idle line reads as 1.
                            tx_q    <= 8'hFF;
                            dout_q  <= rx_q;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= {tx_q[6:0], 1'b1};
                            state_q   <= ST_LO;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout    = dout_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign SD_CLK  = sck_q;
    assign SD_SI   = tx_q[7];
    assign SD_CS_N = cs_n_q;

endmodule

// File: doc/zc_spi_master.md
ZC_SPI_MASTER -- requirements
Module: zc_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCK half-period in clk_sys cycles for fast mode (range 1..255).
REQ-002 SHALL have parameter SLOW_DIV, default 64: SCK half-period in clk_sys cycles when slow=1.
REQ-003 SHALL have port clk_sys, input, 1: the single clock; all logic rises on it.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cs_wr, input, 1: one-cycle strobe that writes the chip-select register.
REQ-006 SHALL have port dat_wr, input, 1: one-cycle strobe that starts a transfer of din.
REQ-007 SHALL have port dat_rd, input, 1: one-cycle strobe that starts a transfer of 8'hFF.
REQ-008 SHALL have port din, input, 8: write data; din[0] is the CS_N value on cs_wr.
REQ-009 SHALL have port slow, input, 1: selects SLOW_DIV; sampled at transfer start.
REQ-010 SHALL have port dout, output, 8: last completed received byte.
REQ-011 SHALL have port busy, output, 1: a transfer is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at transfer completion.
REQ-013 SHALL have port SD_CLK, output, 1: SPI SCK, mode 0, idle low.
REQ-014 SHALL have port SD_SI, output, 1: MOSI, MSB first.
REQ-015 SHALL have port SD_SO, input, 1: MISO.
REQ-016 SHALL have port SD_CS_N, output, 1: registered chip select.

Function
REQ-017 States SHALL be IDLE, LO (SCK low half), HI (SCK high half); a divider counter and a 3-bit bit counter SHALL advance the state.
REQ-018 In IDLE, dat_wr SHALL load the shift register with din; dat_rd SHALL load 8'hFF. Both SHALL latch the divider (slow ? SLOW_DIV : CLK_DIV), set busy, and enter LO on the next cycle.
REQ-019 SD_SI SHALL present bit7 of the shift register from the cycle after the start strobe, and SHALL be 1 in IDLE.
REQ-020 On the LO->HI transition, SD_CLK SHALL rise and SD_SO SHALL be sampled into bit0 of the receive register.
REQ-021 On the HI->LO transition, SD_CLK SHALL fall and the transmit shift register SHALL shift left by one, filling with 1.
REQ-022 Each half SHALL last exactly the latched divider cycles; one byte SHALL take 16×divider cycles from the strobe to the cycle busy falls.
REQ-023 After the 8th HI half, the block SHALL return to IDLE with SD_CLK low; dout SHALL update and done SHALL pulse in the same cycle busy falls.
REQ-024 dat_wr and dat_rd while busy SHALL be ignored; a concurrent read of dout SHALL see the previous byte unchanged.
REQ-025 If dat_wr and dat_rd arrive together in IDLE, dat_wr SHALL win.
REQ-026 cs_wr SHALL set SD_CS_N to din[0] on the next cycle at any time, including mid-transfer; the transfer SHALL continue.
REQ-027 If cs_wr and dat_wr arrive in the same cycle, both SHALL take effect, with din[0] going to CS_N and din going to the shift register.
REQ-028 A change on slow during a transfer SHALL NOT affect it.

Reset
REQ-029 Reset SHALL apply asynchronously: state IDLE, SD_CLK=0, SD_SI=1, SD_CS_N=1, dout=8'hFF, busy=0, done=0, counters 0.
REQ-030 Reset during a transfer SHALL abort it immediately, with no done pulse and no dout update.

Structure
REQ-031 The state enum and the default divider constants SHALL live in shared package zc_spi_pkg.
REQ-032 No sub-module SHALL be used; the divider, bit counter and shifters SHALL stay inline in one always block plus output assigns.

Verification
REQ-033 CLK_DIV=2, slow=0, dat_wr din=8'hA5, SD_SO driving 8'h3C MSB-first on rising edges -> SD_SI carries 1,0,1,0,0,1,0,1; 8 SCK pulses of 4-cycle period; busy falls at cycle 32; dout=8'h3C; done pulses once.
REQ-034 dat_rd with SD_SO held 0 -> SD_SI stays 1 for all 8 bits; dout=8'h00.
REQ-035 dat_wr 8'h11 issued at cycle 10 of a transfer of 8'h40 -> second write ignored; SD_SI sequence matches 8'h40 only; one done pulse.
REQ-036 cs_wr din=0 together with dat_wr din=8'hFE -> SD_CS_N=0 next cycle; transfer of 8'hFE proceeds; a later cs_wr din=1 mid-transfer raises SD_CS_N without disturbing SCK.
REQ-037 slow=1, dat_wr -> SCK half-period 64 cycles; busy high for 1024 cycles; toggling slow mid-transfer changes nothing.
REQ-038 Reset asserted at cycle 7 of a transfer -> SD_CLK=0, SD_SI=1, SD_CS_N=1, busy=0 immediately; no done pulse; dout=8'hFF.
